maddness_ctrl: RTL and testbench

- Sequencer for the MADDNESS inference core and its configuration memory.
- Streams configuration words (split indices, split values, precalculated results) into the memory's `in_num`/`in_addr`/`write` port.
- Gates input admission until configuration is complete and drains in-flight inferences before any reconfiguration.
- Generates `out_valid` aligned to the core's fixed pipeline latency; sits between the host/DMA front end and the core.

---
 rtl/maddness_ctrl.sv | 141 ++++++++++++++
 tb/tb_maddness_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/maddness_ctrl.sv
// Sequencer for the MADDNESS core: streams configuration words into the core's memory,
// gates sample admission until configuration is complete, and tracks in-flight samples.
module maddness_ctrl #(
  parameter int layers     = 4,
  parameter int trees      = 4,
  parameter int output_len = 8,
  parameter int bits       = 8,
  localparam int MEMSIZE   = layers*trees + (2**layers-1)*trees + trees*output_len*(2**layers),
  localparam int ADDR_LEN  = $clog2(MEMSIZE),
  localparam int LAT       = layers + $clog2(trees),
  localparam int INF_W     = $clog2(LAT+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  input  logic [bits-1:0]     cfg_data,
  output logic                cfg_ready,
  output logic                cfg_done,
  output logic                configured,
  output logic [bits-1:0]     mem_num,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_write,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                out_valid,
  output logic [INF_W-1:0]    inflight
);

  typedef enum logic [2:0] {
    UNCFG,
    LOAD,
    SETTLE,
    ACTIVE,
    DRAIN
  } state_e;

  localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(MEMSIZE-1);

  state_e              state_q, state_d;
  logic [ADDR_LEN-1:0] cnt_q, cnt_d;
  logic                mem_write_q;
  logic [ADDR_LEN-1:0] mem_addr_q;
  logic [bits-1:0]     mem_num_q;
  logic                cfg_done_q;
  logic [INF_W-1:0]    inflight_q, inflight_d;
  logic [LAT-1:0]      vld_q;

  logic beat;
  logic fire;

  assign beat = cfg_valid & (state_q == LOAD);
  assign fire = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cfg_ready  = 1'b0;
    in_ready   = 1'b0;
    configured = 1'b0;
    case (state_q)
      UNCFG: begin
        if (cfg_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        cfg_ready = 1'b1;
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        state_d = ACTIVE;
      end
      ACTIVE: begin
        configured = 1'b1;
        // A reconfiguration request wins over sample admission in the same cycle.
        in_ready   = ~cfg_start;
        if (cfg_start) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight_q == '0) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = UNCFG;
      end
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (fire && !vld_q[LAT-1]) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!fire && vld_q[LAT-1]) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNCFG;
      cnt_q       <= '0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_num_q   <= '0;
      cfg_done_q  <= 1'b0;
      inflight_q  <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_write_q <= beat;
      if (beat) begin
        mem_addr_q <= cnt_q;
        mem_num_q  <= cfg_data;
      end
      cfg_done_q  <= (state_q == SETTLE);
      inflight_q  <= inflight_d;
      // Mirrors the core pipeline: a sample admitted now emerges LAT cycles later.
      vld_q       <= {vld_q[LAT-2:0], fire};
    end
  end

  assign cfg_done  = cfg_done_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_num   = mem_num_q;
  assign out_valid = vld_q[LAT-1];
  assign inflight  = inflight_q;

endmodule

// File: tb/tb_maddness_ctrl.sv
// Randomised scoreboard bench for maddness_ctrl: a driver predicts writes and result timing,
// a negedge monitor compares every DUT output against those predictions.
module tb_maddness_ctrl;

  localparam int LAYERS     = 4;
  localparam int TREES      = 4;
  localparam int OUTPUT_LEN = 8;
  localparam int BITS       = 8;
  localparam int MEMSIZE    = LAYERS*TREES + (2**LAYERS-1)*TREES + TREES*OUTPUT_LEN*(2**LAYERS);
  localparam int ADDR_LEN   = $clog2(MEMSIZE);
  localparam int LAT        = LAYERS + $clog2(TREES);
  localparam int INF_W      = $clog2(LAT+1);

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_start;
  logic                cfg_valid;
  logic [BITS-1:0]     cfg_data;
  logic                cfg_ready;
  logic                cfg_done;
  logic                configured;
  logic [BITS-1:0]     mem_num;
  logic [ADDR_LEN-1:0] mem_addr;
  logic                mem_write;
  logic                in_valid;
  logic                in_ready;
  logic                out_valid;
  logic [INF_W-1:0]    inflight;

  maddness_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .cfg_done   (cfg_done),
    .configured (configured),
    .mem_num    (mem_num),
    .mem_addr   (mem_addr),
    .mem_write  (mem_write),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .inflight   (inflight)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int at;
  } wr_t;

  wr_t wr_q[$];
  int  out_q[$];

  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 1'b0;
  bit  exp_cr, exp_ir, exp_cf, exp_cd;

  task automatic chk(input string name, input logic [31:0] act, input int expv);
    checks++;
    if (act !== 32'(expv)) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  // Samples admitted before this cycle whose result cycle has not yet passed.
  function automatic int model_inflight();
    int n = 0;
    foreach (out_q[i]) begin
      if (out_q[i] - LAT < cyc && cyc <= out_q[i]) n++;
    end
    return n;
  endfunction

  wr_t mon_w;
  bit  exp_w, exp_o;
  int  exp_inf;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cfg_ready", cfg_ready, exp_cr);
      chk("in_ready", in_ready, exp_ir);
      chk("configured", configured, exp_cf);
      chk("cfg_done", cfg_done, exp_cd);
      exp_inf = model_inflight();
      chk("inflight", inflight, exp_inf);
      exp_w = (wr_q.size() > 0) && (wr_q[0].at == cyc);
      chk("mem_write", mem_write, exp_w);
      if (exp_w) begin
        mon_w = wr_q.pop_front();
        if (mem_write === 1'b1) begin
          chk("mem_addr", mem_addr, mon_w.addr);
          chk("mem_num", mem_num, mon_w.data);
        end
      end
      exp_o = (out_q.size() > 0) && (out_q[0] == cyc);
      chk("out_valid", out_valid, exp_o);
      if (exp_o) void'(out_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input bit cr, input bit ir, input bit cf, input bit cd);
    exp_cr = cr;
    exp_ir = ir;
    exp_cf = cf;
    exp_cd = cd;
  endtask

  // mode 0: continuous, data = address; mode 1: every third cycle idle; mode 2: random.
  // abort_at >= 0 pulses reset once that many words have been accepted.
  task automatic do_load(input int mode, input int abort_at);
    int cnt = 0;
    int k = 0;
    while (cnt < MEMSIZE) begin
      tick();
      if (abort_at >= 0 && cnt == abort_at) begin
        rst       = 1'b1;
        cfg_valid = 1'b1;
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        set_exp(1, 0, 0, 0);
        tick();
        rst       = 1'b0;
        cfg_valid = 1'b0;
        set_exp(0, 0, 0, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_mem_num", mem_num, 0);
        chk("abort_mem_write", mem_write, 0);
        chk("abort_inflight", inflight, 0);
        return;
      end
      cfg_start = (mode == 2) ? ($urandom_range(0, 7) == 0) : 1'b0;
      case (mode)
        0:       cfg_valid = 1'b1;
        1:       cfg_valid = (k % 3 != 2);
        default: cfg_valid = ($urandom_range(0, 3) != 0);
      endcase
      cfg_data = (mode == 0) ? BITS'(cnt) : BITS'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      set_exp(1, 0, 0, 0);
      if (cfg_valid) begin
        wr_q.push_back('{cnt, int'(cfg_data), cyc + 1});
        cnt++;
      end
      k++;
    end
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'($urandom_range(0, 1));
    in_valid  = 1'($urandom_range(0, 1));
    set_exp(0, 0, 0, 0);
    tick();
    cfg_valid = 1'($urandom_range(0, 1));
    in_valid  = 1'b0;
    set_exp(0, 1, 1, 1);
  endtask

  task automatic active_cycle(input bit iv, input bit cs);
    tick();
    in_valid  = iv;
    cfg_start = cs;
    cfg_valid = 1'($urandom_range(0, 1));
    cfg_data  = BITS'($urandom);
    set_exp(0, !cs, 1, 0);
    if (iv && !cs) out_q.push_back(cyc + LAT);
  endtask

  task automatic do_drain();
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      in_valid  = 1'($urandom_range(0, 1));
      cfg_start = 1'($urandom_range(0, 1));
      cfg_valid = 1'($urandom_range(0, 1));
      set_exp(0, 0, 0, 0);
      if (model_inflight() == 0) return;
    end
  endtask

  task automatic start_from_uncfg();
    tick();
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    in_valid  = 1'b0;
    set_exp(0, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    in_valid  = 1'b0;
    set_exp(0, 0, 0, 0);
    repeat (3) tick();
    rst    = 1'b0;
    chk_en = 1'b1;
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_num", mem_num, 0);

    // Unconfigured: words and samples must be refused.
    repeat (10) begin
      tick();
      cfg_valid = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
    end

    start_from_uncfg();
    do_load(0, -1);

    for (int k = 0; k < 14; k++) begin
      active_cycle((k <= 2) || (k == 5), 1'b0);
    end

    repeat (4) active_cycle(1'b1, 1'b0);
    active_cycle(1'b1, 1'b1);
    do_drain();
    do_load(1, -1);

    repeat (150) active_cycle($urandom_range(0, 3) != 0, 1'b0);
    active_cycle(1'b1, 1'b1);
    do_drain();
    do_load(2, -1);

    repeat (LAT + 2) active_cycle(1'b0, 1'b0);
    active_cycle(1'b0, 1'b1);
    do_drain();
    do_load(2, 300);

    start_from_uncfg();
    do_load(0, -1);
    repeat (20) active_cycle(1'b1, 1'b0);
    repeat (LAT + 3) active_cycle(1'b0, 1'b0);

    chk("writes_outstanding", wr_q.size(), 0);
    chk("results_outstanding", out_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
